// File: rtl/scan_fifo.sv
// First-word-fall-through word FIFO between the DMA master and the scan shifter.
// RAM holds every stored word; data_out is a prefetched copy of the head entry.
module scan_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int AF_MARGIN  = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  push;
    logic                  pop;
    logic                  head_bypass;

    always_comb begin
        push       = wr_en & ~full;
        pop        = rd_en & ~empty;
        rd_ptr_nxt = rd_ptr + AW'(pop);
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
        // The word being written is the next head only when nothing older remains.
        head_bypass = push && (wr_ptr == rd_ptr_nxt);
    end

    always_ff @(posedge aclk) begin
        if (push && !areset && !clear) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            data_out <= '0;
        end else if (!clear && count_nxt != '0) begin
            data_out <= head_bypass ? data_in : mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == FULL_LVL);
            almost_full <= (count_nxt >= AF_LVL);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_fifo.sv
// Self-checking bench for scan_fifo: queue scoreboard, vector table, corner sequences.
module tb_scan_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AFM   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          aclk;
    logic          areset;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    scan_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_MARGIN  (AFM)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .clear       (clear),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout;

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        int            cnt;
        logic          emp;
        logic          ovf;
        logic          unf;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare every output.
    task automatic step(input logic rst, input logic wr, input logic rd,
                        input logic clr, input logic [DW-1:0] din);
        bit f;
        bit e;
        areset  = rst;
        wr_en   = wr;
        rd_en   = rd;
        clear   = clr;
        data_in = din;
        if (rst) begin
            sb_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else if (clr) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            f = (sb_q.size() == DEPTH);
            e = (sb_q.size() == 0);
            if (wr && f) m_ovf = 1'b1;
            if (rd && e) m_unf = 1'b1;
            if (rd && !e) begin
                chk("sb_pop_data", data_out, sb_q[0]);
                void'(sb_q.pop_front());
            end
            if (wr && !f) sb_q.push_back(din);
        end
        if (sb_q.size() > 0) m_dout = sb_q[0];
        @(posedge aclk);
        #1;
        chk("count", DW'(count), DW'(sb_q.size()));
        chk("empty", DW'(empty), DW'(sb_q.size() == 0));
        chk("full", DW'(full), DW'(sb_q.size() == DEPTH));
        chk("almost_full", DW'(almost_full),
            DW'(sb_q.size() >= DEPTH - AFM));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("underflow", DW'(underflow), DW'(m_unf));
        chk("data_out", data_out, m_dout);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, base + DW'(i));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 1, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         1, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_0000, 0, 1'b1, 1'b0, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5, 1, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0001, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0001};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b0, 32'h0000_0001};

        areset  = 1'b1;
        clear   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout  = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("reset_empty", DW'(empty), 32'd1);
        chk("reset_dout", data_out, 32'd0);

        // Fill with 0..511, checking the almost_full and full edges.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, DW'(i));
            if (i == 494) chk("af_before", DW'(almost_full), 32'd0);
            if (i == 495) chk("af_rise", DW'(almost_full), 32'd1);
            if (i == 510) chk("full_before", DW'(full), 32'd0);
        end
        chk("full_rise", DW'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("ovf_set", DW'(overflow), 32'd1);
        chk("ovf_count", DW'(count), 32'd512);

        // Full pop plus push: push is dropped, pop succeeds.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hBAD0_0001);
        chk("full_pp_count", DW'(count), 32'd511);
        chk("full_pp_head", data_out, 32'd1);

        // Drain with continuous rd_en; scoreboard checks the order.
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, '0);
            if (i == 0) chk("full_fall", DW'(full), 32'd0);
        end
        chk("drain_empty", DW'(empty), 32'd1);
        chk("drain_hold", data_out, 32'h0000_01FF);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("unf_set", DW'(underflow), 32'd1);

        // Vector table from a fresh reset: empty boundary and clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int v = 0; v < 7; v++) begin
            step(1'b0, vecs[v].wr, vecs[v].rd, vecs[v].clr, vecs[v].din);
            chk($sformatf("vec%0d_count", v), DW'(count), DW'(vecs[v].cnt));
            chk($sformatf("vec%0d_empty", v), DW'(empty), DW'(vecs[v].emp));
            chk($sformatf("vec%0d_ovf", v), DW'(overflow), DW'(vecs[v].ovf));
            chk($sformatf("vec%0d_unf", v), DW'(underflow), DW'(vecs[v].unf));
            chk($sformatf("vec%0d_dout", v), data_out, vecs[v].dout);
        end

        // Steady state at 100 words across many pointer wraps.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        push_n(100, 32'd0);
        for (int i = 0; i < 1000; i++) begin
            chk("steady_head", data_out, DW'(i));
            step(1'b0, 1'b1, 1'b1, 1'b0, DW'(100 + i));
            if (count != CW'(100)) chk("steady_count", DW'(count), 32'd100);
        end
        chk("steady_end_head", data_out, 32'd1000);

        // Clear wins over simultaneous push and pop.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        push_n(300, 32'h0001_0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h7777_7777);
        chk("clr_count", DW'(count), 32'd0);
        chk("clr_af", DW'(almost_full), 32'd0);
        chk("clr_ovf", DW'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
        chk("clr_push_dout", data_out, 32'hA5A5_A5A5);

        // Reset in the middle of concurrent traffic at count 37.
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        push_n(37, 32'h0002_0000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h5555_5555);
        chk("mid_rst_count", DW'(count), 32'd0);
        chk("mid_rst_dout", data_out, 32'd0);
        for (int i = 0; i < 5; i++) idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        push_n(2, 32'h0003_0000);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_empty", DW'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
